// File: rtl/eau_sched.sv
// EAU issue scheduler: sizes each issue as min(s1_num, s2_num, rem) and gates it on downstream credits.
// Optional EAU_SCHED_PERF_EN adds stall performance counters.
module eau_sched #(
  parameter int unsigned VLEN    = 256,
  parameter int unsigned BSW     = 5,
  parameter int unsigned CNTW    = 16,
  parameter int unsigned CREDITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [CNTW-1:0] job_len,
  output logic            busy,
  output logic            done,
  input  logic            s1_valid,
  input  logic [BSW:0]    s1_num,
  output logic            s1_ready,
  output logic [BSW:0]    s1_used,
  input  logic            s2_valid,
  input  logic [BSW:0]    s2_num,
  output logic            s2_ready,
  output logic [BSW:0]    s2_used,
  output logic [BSW:0]    eau_num,
  output logic            o_valid,
  output logic            o_last,
  input  logic            cred_ret,
  output logic            err_cred
`ifdef EAU_SCHED_PERF_EN
  ,
  output logic [31:0]     perf_stall_cred,
  output logic [31:0]     perf_stall_in
`endif
);

  localparam int unsigned NW = BSW + 1;
  localparam int unsigned BS = 1 << BSW;
  localparam int unsigned CW = $clog2(CREDITS + 1);

  if ((VLEN % BS) != 0) begin : g_vlen_chk
    $error("VLEN must be a multiple of the EAU element count");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] rem;
  logic [CW-1:0]   cred;
  logic [NW-1:0]   rem_cap, n12, n;
  logic            issue, fin;

  // Issue sizing and the same-cycle stream/EAU handshake.
  always_comb begin
    rem_cap   = (rem >= CNTW'(BS)) ? NW'(BS) : NW'(rem);
    n12       = (s1_num < s2_num) ? s1_num : s2_num;
    n         = (n12 < rem_cap) ? n12 : rem_cap;
    issue     = (state == RUN) && s1_valid && s2_valid && (s1_num != '0) && (s2_num != '0)
                && (cred != '0) && !abort;
    fin       = issue && (CNTW'(n) == rem);
    state_nxt = state;
    eau_num   = '0;
    s1_ready  = 1'b0;
    s2_ready  = 1'b0;
    s1_used   = '0;
    s2_used   = '0;
    if (issue) begin
      eau_num  = n;
      s1_ready = 1'b1;
      s2_ready = 1'b1;
      s1_used  = n;
      s2_used  = n;
    end
    case (state)
      IDLE:    if (start && (job_len != '0)) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (fin) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, job counter, credits and the registered EAU-output tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      err_cred <= 1'b0;
      rem      <= '0;
      cred     <= CW'(CREDITS);
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= fin || ((state == IDLE) && start && (job_len == '0));
      o_valid <= issue;
      o_last  <= fin;
      if ((state == IDLE) && start) rem <= job_len;
      else if ((state == RUN) && abort) rem <= '0;
      else if (issue) rem <= rem - CNTW'(n);
      if (issue && !cred_ret) begin
        cred <= cred - CW'(1);
      end else if (!issue && cred_ret) begin
        if (cred == CW'(CREDITS)) err_cred <= 1'b1;
        else cred <= cred + CW'(1);
      end
    end
  end

`ifdef EAU_SCHED_PERF_EN
  // Stall counters, active only while a job is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cred <= '0;
      perf_stall_in   <= '0;
    end else if (state == RUN) begin
      if (s1_valid && s2_valid && (cred == '0)) perf_stall_cred <= perf_stall_cred + 32'd1;
      if (!s1_valid || !s2_valid || (s1_num == '0) || (s2_num == '0))
        perf_stall_in <= perf_stall_in + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eau_sched.sv
// Randomized + directed bench for eau_sched with a job/credit reference model and an output scoreboard.
module tb_eau_sched;
  localparam int BSW = 5;
  localparam int CNTW = 16;
  localparam int CREDITS = 4;
  localparam int BS = 1 << BSW;

  logic            clk, rst_n, start, abort, busy, done;
  logic [CNTW-1:0] job_len;
  logic            s1_valid, s2_valid, s1_ready, s2_ready;
  logic [BSW:0]    s1_num, s2_num, s1_used, s2_used, eau_num;
  logic            o_valid, o_last, cred_ret, err_cred;
`ifdef EAU_SCHED_PERF_EN
  logic [31:0]     perf_stall_cred, perf_stall_in;
`endif

  eau_sched #(.VLEN(256), .BSW(BSW), .CNTW(CNTW), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .job_len(job_len),
    .busy(busy), .done(done),
    .s1_valid(s1_valid), .s1_num(s1_num), .s1_ready(s1_ready), .s1_used(s1_used),
    .s2_valid(s2_valid), .s2_num(s2_num), .s2_ready(s2_ready), .s2_used(s2_used),
    .eau_num(eau_num), .o_valid(o_valid), .o_last(o_last),
    .cred_ret(cred_ret), .err_cred(err_cred)
`ifdef EAU_SCHED_PERF_EN
    , .perf_stall_cred(perf_stall_cred), .perf_stall_in(perf_stall_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; bit last; } ov_t;
  ov_t ov_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  n_vec = 0, n_err = 0;
  bit  mon_en = 0;

  // Reference model: job in progress, elements left, credits held.
  bit m_run, m_flush, m_err;
  int m_rem, m_cred;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: each cycle, o_valid/done must match exactly what the scoreboard holds for it.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mon_en) begin
      if (ov_q.size() > 0 && ov_q[0].cyc <= cyc) begin
        ov_t e;
        e = ov_q.pop_front();
        chk("o_valid", o_valid, 1);
        if (o_valid) chk("o_last", o_last, e.last);
      end else begin
        chk("o_valid_idle", o_valid, 0);
      end
      if (done_q.size() > 0 && done_q[0] <= cyc) begin
        void'(done_q.pop_front());
        chk("done", done, 1);
      end else begin
        chk("done_idle", done, 0);
      end
    end
  end

  task automatic do_reset(input bit check_now);
    @(negedge clk);
    rst_n = 0;
    start = 0; abort = 0; job_len = '0; cred_ret = 0;
    s1_valid = 0; s2_valid = 0; s1_num = '0; s2_num = '0;
    #1;
    if (check_now) begin
      chk("rst_o_valid", o_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_cred", err_cred, 0);
      chk("rst_eau_num", eau_num, 0);
    end
    m_run = 0; m_flush = 0; m_err = 0; m_rem = 0; m_cred = CREDITS;
    ov_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_cycle(input bit st, input bit ab, input int len, input bit v1, input int n1,
                           input bit v2, input int n2, input bit ret);
    bit iss;
    int n, cap;
    @(negedge clk);
    start = st; abort = ab; job_len = CNTW'(len); cred_ret = ret;
    s1_valid = v1; s1_num = (BSW+1)'(n1); s2_valid = v2; s2_num = (BSW+1)'(n2);
    #1;
    iss = m_run && v1 && v2 && n1 != 0 && n2 != 0 && m_cred != 0 && !ab;
    n   = (n1 < n2) ? n1 : n2;
    cap = (m_rem < BS) ? m_rem : BS;
    if (cap < n) n = cap;
    if (!iss) n = 0;
    chk("eau_num", eau_num, n);
    chk("s1_used", s1_used, n);
    chk("s2_used", s2_used, n);
    chk("s1_ready", s1_ready, iss);
    chk("s2_ready", s2_ready, iss);
    chk("busy", busy, m_run || m_flush);
    chk("err_cred", err_cred, m_err);
    // Advance the model to the state after the coming edge.
    if (iss && !ret) m_cred--;
    else if (!iss && ret) begin
      if (m_cred == CREDITS) m_err = 1;
      else m_cred++;
    end
    if (m_flush) begin
      m_flush = 0;
    end else if (m_run) begin
      if (ab) begin
        m_run = 0; m_rem = 0;
      end else if (iss) begin
        m_rem -= n;
        ov_q.push_back('{cyc + 1, m_rem == 0});
        if (m_rem == 0) begin
          m_run = 0; m_flush = 1;
          done_q.push_back(cyc + 1);
        end
      end
    end else if (st) begin
      if (len == 0) done_q.push_back(cyc + 1);
      else begin m_run = 1; m_rem = len; end
    end
  endtask

  task automatic restore_credits();
    for (int k = 0; k < 16 && (m_cred < CREDITS || m_run || m_flush); k++)
      run_cycle(0, m_run, 0, 0, 0, 0, 0, m_cred < CREDITS);
  endtask

  initial begin
    rst_n = 0;
    do_reset(1);
    mon_en = 1;

    // 70 elements at 32/cycle: 32, 32, 6.
    run_cycle(1, 0, 70, 0, 0, 0, 0, 0);
    repeat (5) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    restore_credits();

    // 40 elements limited by stream 1 at 10.
    run_cycle(1, 0, 40, 0, 0, 0, 0, 0);
    repeat (4) run_cycle(0, 0, 0, 1, 10, 1, 25, 1);
    repeat (2) run_cycle(0, 0, 0, 1, 10, 1, 25, 0);
    restore_credits();

    // Credit exhaustion: 4 issues, stall, one return gives one more issue.
    run_cycle(1, 0, 200, 0, 0, 0, 0, 0);
    repeat (8) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    run_cycle(0, 0, 0, 1, 32, 1, 32, 1);
    repeat (3) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    run_cycle(0, 1, 0, 1, 32, 1, 32, 0);
    restore_credits();

    // Abort on the second issue cycle.
    run_cycle(1, 0, 100, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    run_cycle(0, 1, 0, 1, 32, 1, 32, 0);
    repeat (2) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    restore_credits();

    // Zero-length job, then credit overflow (sticky).
    run_cycle(1, 0, 0, 1, 32, 1, 32, 0);
    repeat (2) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef EAU_SCHED_PERF_EN
    begin
      int p0;
      run_cycle(1, 0, 100, 0, 0, 0, 0, 0);
      p0 = int'(perf_stall_in);
      repeat (5) run_cycle(0, 0, 0, 1, 32, 0, 32, 0);
      run_cycle(0, 1, 0, 1, 32, 1, 32, 0);
      chk("perf_stall_in", int'(perf_stall_in) - p0, 5);
      restore_credits();
    end
`endif

    // Async reset after two issues without returns.
    run_cycle(1, 0, 150, 0, 0, 0, 0, 0);
    repeat (2) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    do_reset(1);
    // Full credits must be back: exactly 4 issues before stalling.
    run_cycle(1, 0, 200, 0, 0, 0, 0, 0);
    repeat (6) run_cycle(0, 0, 0, 1, 32, 1, 32, 0);
    run_cycle(0, 1, 0, 1, 32, 1, 32, 0);
    restore_credits();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int len;
      len = ($urandom % 6 == 0) ? 0 : int'($urandom % 150);
      run_cycle($urandom % 8 == 0, $urandom % 24 == 0, len,
                $urandom % 4 != 0, int'($urandom % (BS + 1)),
                $urandom % 4 != 0, int'($urandom % (BS + 1)),
                $urandom % 3 == 0);
    end
    restore_credits();
    repeat (3) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ov_q_drained", ov_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
